// File: rtl/pe_pkg.sv
// pe_pkg: shared definitions for the three-line priority encoder front end.
//   NUM_REQ            number of request channels
//   CODE_NONE..CODE_T3 2-bit encoder codes, returned by the consumer as ack_code
//   req_vec_t          one bit per request channel
//   code_to_mask()     maps an encoder code to a one-hot channel mask
package pe_pkg;

  localparam int NUM_REQ = 3;

  localparam logic [1:0] CODE_NONE = 2'b00;
  localparam logic [1:0] CODE_T1   = 2'b01;
  localparam logic [1:0] CODE_T2   = 2'b10;
  localparam logic [1:0] CODE_T3   = 2'b11;

  typedef logic [NUM_REQ-1:0] req_vec_t;

  // CODE_NONE selects no channel, so an ack carrying it is harmless.
  function automatic req_vec_t code_to_mask(input logic [1:0] code);
    req_vec_t mask;
    case (code)
      CODE_T1: mask = 3'b001;
      CODE_T2: mask = 3'b010;
      CODE_T3: mask = 3'b100;
      default: mask = 3'b000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/req_capture3_if.sv
// req_capture3_if: request/acknowledge bundle between the request sources and
// consumer (master) and the capture stage (slave).
//   raw_req  [2:0] raw asynchronous request lines (bit 0 -> t1 ... bit 2 -> t3)
//   ack            one-cycle acknowledge strobe
//   ack_code [1:0] encoder code of the channel being acknowledged
//   ovf_clr        clears all overflow flags
//   t1,t2,t3       pending flags towards the encoder
//   ovf      [2:0] sticky per-channel overflow
interface req_capture3_if;
  import pe_pkg::*;

  req_vec_t   raw_req;
  logic       ack;
  logic [1:0] ack_code;
  logic       ovf_clr;
  logic       t1;
  logic       t2;
  logic       t3;
  req_vec_t   ovf;

  modport master (
    output raw_req, ack, ack_code, ovf_clr,
    input  t1, t2, t3, ovf
  );

  modport slave (
    input  raw_req, ack, ack_code, ovf_clr,
    output t1, t2, t3, ovf
  );

endinterface

// File: rtl/req_debounce.sv
// req_debounce: one request channel -- 2-FF synchroniser followed by a
// counter-based debouncer.
//   clk, rst  clock and asynchronous active-high reset
//   i_raw     raw asynchronous request line
//   o_rise    debounced rising-edge accept event (combinational, valid in the
//             cycle before the edge at which the debounced value goes high)
//   o_db      current debounced level
module req_debounce #(
  parameter int DB_CYCLES = 4,
  parameter int CNT_W     = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_rise,
  output logic o_db
);

  // Terminal count: the synchronised value has differed from db for
  // DB_CYCLES consecutive edges once this is reached.
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  logic             r_s1;
  logic             r_s2;
  logic             r_db;
  logic [CNT_W-1:0] r_cnt;

  logic w_diff;
  logic w_hit;

  assign w_diff = r_s2 ^ r_db;
  assign w_hit  = (r_cnt == CNT_MAX);

  // Synchroniser, debounced level and run-length counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1  <= 1'b0;
      r_s2  <= 1'b0;
      r_db  <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_s1 <= i_raw;
      r_s2 <= r_s1;
      if (!w_diff) begin
        // Agreement with db discards any partial run, which is what rejects glitches.
        r_cnt <= '0;
      end else if (w_hit) begin
        r_db  <= r_s2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  // Accept event lines up with the edge at which db is about to rise.
  assign o_rise = r_s2 & ~r_db & w_hit;
  assign o_db   = r_db;

endmodule

// File: rtl/req_capture3.sv
// req_capture3: capture stage for the three-line priority encoder. Each raw
// request is synchronised and debounced; every debounced rising edge sets a
// sticky pending flag (t1..t3) that stays up until the consumer acknowledges
// it with the matching encoder code. A request accepted while its flag is
// still pending, and not being cleared in that cycle, sets the channel's
// sticky overflow bit.
//   clk, rst  clock and asynchronous active-high reset
//   bus       req_capture3_if slave: raw_req, ack, ack_code, ovf_clr in;
//             t1, t2, t3, ovf out (all outputs driven straight from flops)
module req_capture3
  import pe_pkg::*;
#(
  parameter int DB_CYCLES = 4,
  parameter int CNT_W     = 3
) (
  input  logic           clk,
  input  logic           rst,
  req_capture3_if.slave  bus
);

  req_vec_t w_rise;
  req_vec_t w_db;
  req_vec_t w_clr;
  req_vec_t w_ovf_set;
  req_vec_t r_pend;
  req_vec_t r_ovf;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_ch
    req_debounce #(
      .DB_CYCLES (DB_CYCLES),
      .CNT_W     (CNT_W)
    ) u_debounce (
      .clk    (clk),
      .rst    (rst),
      .i_raw  (bus.raw_req[g]),
      .o_rise (w_rise[g]),
      .o_db   (w_db[g])
    );
  end

  // Channel selected for clearing this cycle; nothing unless ack is strobed.
  always_comb begin
    w_clr = 3'b000;
    if (bus.ack) begin
      w_clr = code_to_mask(bus.ack_code);
    end else begin
      w_clr = 3'b000;
    end
  end

  // A second request only counts as lost if the first one is not being
  // serviced in the same cycle.
  assign w_ovf_set = w_rise & r_pend & ~w_clr;

  // Pending flags (set beats clear) and sticky overflow (set beats ovf_clr).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend <= 3'b000;
      r_ovf  <= 3'b000;
    end else begin
      r_pend <= (r_pend & ~w_clr) | w_rise;
      if (bus.ovf_clr) begin
        r_ovf <= w_ovf_set;
      end else begin
        r_ovf <= r_ovf | w_ovf_set;
      end
    end
  end

  assign bus.t1  = r_pend[0];
  assign bus.t2  = r_pend[1];
  assign bus.t3  = r_pend[2];
  assign bus.ovf = r_ovf;

endmodule
